// File: rtl/word_concatenator.sv
// Packs WIDTH-bit input words into PACK-word beats, with valid/ready on both sides.
// A frame is NUM_WORDS input words. Its final beat is zero-padded above the last word and flagged last.
module word_concatenator #(
    parameter int WIDTH     = 8,
    parameter int PACK      = 4,
    parameter int NUM_WORDS = 1024
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [WIDTH-1:0]      i_in_data,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    output logic [WIDTH*PACK-1:0] o_out_data,
    output logic                  o_out_valid,
    output logic                  o_out_last,
    input  logic                  i_out_ready
);
    localparam int LW        = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int FW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int ACC_LANES = (PACK > 1) ? PACK - 1 : 1;

    logic [LW-1:0]                    lane_q, lane_d;
    logic [FW-1:0]                    frame_q, frame_d;
    logic [ACC_LANES-1:0][WIDTH-1:0]  acc_q;
    logic [PACK-1:0][WIDTH-1:0]       beat;
    logic [WIDTH*PACK-1:0]            data_q, data_d;
    logic                             valid_q, valid_d;
    logic                             last_q, last_d;
    logic                             accept, frame_end, complete;

    assign o_in_ready = !i_reset && (!valid_q || i_out_ready);
    assign accept     = i_in_valid && o_in_ready;
    assign frame_end  = (frame_q == FW'(NUM_WORDS - 1));
    assign complete   = (lane_q == LW'(PACK - 1)) || frame_end;

    // Candidate beat: held lanes below the current lane, new word at it, zeros above.
    for (genvar k = 0; k < PACK; k++) begin : g_lane
        if (k < PACK - 1) begin : g_acc
            assign beat[k] = (LW'(k) < lane_q)  ? acc_q[k]  :
                             (LW'(k) == lane_q) ? i_in_data : '0;
        end else begin : g_top
            assign beat[k] = (LW'(k) == lane_q) ? i_in_data : '0;
        end
    end

    if (PACK > 1) begin : g_accum
        logic [ACC_LANES-1:0][WIDTH-1:0] acc_d;

        always_comb begin
            acc_d = acc_q;
            if (accept) begin
                if (complete) begin
                    acc_d = '0;
                end else begin
                    for (int k = 0; k < PACK - 1; k++) begin
                        if (LW'(k) == lane_q) acc_d[k] = i_in_data;
                    end
                end
            end
        end

        always_ff @(posedge i_clock or posedge i_reset) begin
            if (i_reset) acc_q <= '0;
            else         acc_q <= acc_d;
        end
    end else begin : g_no_accum
        assign acc_q = '0;
    end

    always_comb begin
        lane_d  = lane_q;
        frame_d = frame_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (valid_q && i_out_ready) valid_d = 1'b0;
        if (accept) begin
            frame_d = frame_end ? '0 : frame_q + 1'b1;
            if (complete) begin
                lane_d  = '0;
                data_d  = beat;
                valid_d = 1'b1;
                last_d  = frame_end;
            end else begin
                lane_d  = lane_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            lane_q  <= '0;
            frame_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            lane_q  <= lane_d;
            frame_q <= frame_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign o_out_data  = data_q;
    assign o_out_valid = valid_q;
    assign o_out_last  = last_q;
endmodule
